// File: rtl/seq_mul_shift_add.sv
// Sequential shift-and-add multiplier with start/busy/done handshake and early exit.
// Define SIGNED_MUL_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_mul_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, nxt;
  logic [2*WIDTH-1:0]   m, acc, acc_add, fin;
  logic [WIDTH-1:0]     q, q_sh, a_mag, b_mag;
  logic [CNT_W-1:0]     cnt;
  logic                 accept, zero_op, last;

`ifdef SIGNED_MUL_EN
  logic                 sgn;
  assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
  assign fin   = sgn ? (~acc_add + 1'b1) : acc_add;
`else
  assign a_mag = a_in;
  assign b_mag = b_in;
  assign fin   = acc_add;
`endif

  assign ready   = (state == IDLE) || (state == DONE);
  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign accept  = start && ready;
  assign zero_op = (a_in == '0) || (b_in == '0);

  assign acc_add = q[0] ? (acc + m) : acc;
  assign q_sh    = q >> 1;
  // Stop as soon as no multiplier bits remain, bounding latency by MSB position.
  assign last    = (q_sh == '0) || (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             nxt = zero_op ? DONE : CALC;
        else if (state == DONE) nxt = IDLE;
      end
      CALC:    if (last) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SIGNED_MUL_EN
      sgn     <= 1'b0;
`endif
    end else if (accept) begin
      m   <= {{WIDTH{1'b0}}, a_mag};
      q   <= b_mag;
      acc <= '0;
      cnt <= '0;
`ifdef SIGNED_MUL_EN
      sgn <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
      // Zero shortcut: result known immediately, never a negative zero.
      if (zero_op) product <= '0;
    end else if (state == CALC) begin
      acc <= acc_add;
      m   <= m << 1;
      q   <= q_sh;
      cnt <= cnt + 1'b1;
      if (last) product <= fin;
    end
  end

endmodule
